// File: rtl/risc16_io_pkg.sv
// Shared constants and types for the risc16 memory-mapped I/O block.
// Optional build macro RISC16_IO_PARITY_EN adds the UART parity state.
package risc16_io_pkg;

    localparam logic [15:0] IO_BASE     = 16'h0200;
    localparam logic [15:0] ADDR_LED_LO = 16'h0200;
    localparam logic [15:0] ADDR_LED_HI = 16'h0202;
    localparam logic [15:0] ADDR_TXDATA = 16'h0204;
    localparam logic [15:0] ADDR_STATUS = 16'h0206;

    // STATUS register bit positions
    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef RISC16_IO_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/risc16_io_fifo.sv
// Small synchronous FIFO for the UART transmitter; o_data is valid while not empty.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module risc16_io_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers are log2(DEPTH) wide, so they wrap naturally for power-of-2 depths.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/risc16_io.sv
// risc16 I/O window at 0x200-0x207: LED register, buffered UART TX and status.
// Define RISC16_IO_PARITY_EN to append an even parity bit to every frame.
module risc16_io
    import risc16_io_pkg::*;
#(
    parameter int CLK_HZ     = 25_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        oe,
    input  logic        we,
    output logic [15:0] rdata,
    output logic        hit,
    output logic [23:0] led,
    output logic        txd
);

    localparam int DIV    = CLK_HZ / BAUD;
    localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);

    // Byte address bit 0 never participates in decode.
    logic w_unused;
    assign w_unused = addr[0];

    logic [15:0] w_word;
    logic        w_wr;
    logic        w_push_req;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [7:0]  w_fifo_data;
    logic [15:0] w_status;

    logic [23:0]       r_led;
    logic              r_ovf;
    tx_state_t         r_state;
    tx_state_t         w_state_next;
    logic [BAUD_W-1:0] r_baud;
    logic [BAUD_W-1:0] w_baud_next;
    logic [2:0]        r_bit;
    logic [2:0]        w_bit_next;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_next;
    logic              r_txd;
    logic              w_txd_next;
    logic              w_baud_end;

    assign w_word     = {addr[15:1], 1'b0};
    assign hit        = (addr[15:3] == IO_BASE[15:3]);
    assign w_wr       = we & hit;
    assign w_push_req = w_wr & (w_word == ADDR_TXDATA);
    assign led        = r_led;
    assign txd        = r_txd;
    assign w_baud_end = (r_baud == BAUD_LAST);

    risc16_io_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push_req),
        .i_data  (wdata[7:0]),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_status           = 16'h0000;
        w_status[ST_BUSY]  = (r_state != TX_IDLE);
        w_status[ST_FULL]  = w_full;
        w_status[ST_EMPTY] = w_empty;
        w_status[ST_OVF]   = r_ovf;
    end

    always_comb begin
        rdata = 16'h0000;
        if (hit && oe) begin
            case (w_word)
                ADDR_LED_LO: rdata = r_led[15:0];
                ADDR_LED_HI: rdata = {8'h00, r_led[23:16]};
                ADDR_STATUS: rdata = w_status;
                default:     rdata = 16'h0000;
            endcase
        end
    end

    // A push into a full FIFO is dropped unless the transmitter pops the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_led <= 24'h000000;
            r_ovf <= 1'b0;
        end else begin
            if (w_wr && w_word == ADDR_LED_LO) begin
                r_led[15:0] <= wdata;
            end
            if (w_wr && w_word == ADDR_LED_HI) begin
                r_led[23:16] <= wdata[7:0];
            end
            if (w_wr && w_word == ADDR_STATUS) begin
                r_ovf <= 1'b0;
            end else if (w_push_req && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Data bits rotate rather than shift, so after 8 bits r_shift holds the byte again.
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud + 1'b1;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        case (r_state)
            TX_IDLE: begin
                w_baud_next = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_fifo_data;
                    w_state_next = TX_START;
                end
            end
            TX_START: begin
                if (w_baud_end) begin
                    w_baud_next  = '0;
                    w_bit_next   = 3'd0;
                    w_state_next = TX_DATA;
                end
            end
            TX_DATA: begin
                if (w_baud_end) begin
                    w_baud_next  = '0;
                    w_shift_next = {r_shift[0], r_shift[7:1]};
                    w_bit_next   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_bit_next = 3'd0;
`ifdef RISC16_IO_PARITY_EN
                        w_state_next = TX_PARITY;
`else
                        w_state_next = TX_STOP;
`endif
                    end
                end
            end
`ifdef RISC16_IO_PARITY_EN
            TX_PARITY: begin
                if (w_baud_end) begin
                    w_baud_next  = '0;
                    w_state_next = TX_STOP;
                end
            end
`endif
            TX_STOP: begin
                if (w_baud_end) begin
                    w_baud_next = '0;
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_fifo_data;
                        w_state_next = TX_START;
                    end else begin
                        w_state_next = TX_IDLE;
                    end
                end
            end
            default: begin
                w_baud_next  = '0;
                w_state_next = TX_IDLE;
            end
        endcase

        // Line level is registered from the next state so txd never glitches.
        case (w_state_next)
            TX_START: w_txd_next = 1'b0;
            TX_DATA:  w_txd_next = w_shift_next[0];
`ifdef RISC16_IO_PARITY_EN
            TX_PARITY: w_txd_next = ^w_shift_next;
`endif
            default:  w_txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= TX_IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_txd   <= w_txd_next;
        end
    end

endmodule

// File: tb/tb_risc16_io.sv
// Directed self-checking bench for risc16_io at DIV=4 (CLK_HZ=4, BAUD=1), FIFO_DEPTH=4.
// Honours RISC16_IO_PARITY_EN when it is defined for the build.
module tb_risc16_io;

    localparam int DIV = 4;
`ifdef RISC16_IO_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic [15:0] wdata = 16'h0000;
    logic        oe = 1'b0;
    logic        we = 1'b0;
    logic [15:0] rdata;
    logic        hit;
    logic [23:0] led;
    logic        txd;

    int n_checks = 0;
    int n_errors = 0;

    risc16_io #(
        .CLK_HZ     (4),
        .BAUD       (1),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .wdata (wdata),
        .oe    (oe),
        .we    (we),
        .rdata (rdata),
        .hit   (hit),
        .led   (led),
        .txd   (txd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the clock edge; the write lands on the next edge.
    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
        $display("write addr=%h data=%h", a, d);
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d);
        addr = a;
        oe   = 1'b1;
        #1;
        d  = rdata;
        oe = 1'b0;
        $display("read  addr=%h data=%h", a, d);
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
`ifdef RISC16_IO_PARITY_EN
        if (idx == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Called just after the edge that entered START; leaves just after the frame's last edge.
    task automatic check_frame(input logic [7:0] d);
        for (int b = 0; b < FRAME_BITS; b++) begin
            for (int c = 0; c < DIV; c++) begin
                check($sformatf("frame_%h_bit%0d_c%0d", d, b, c), {31'b0, txd}, {31'b0, exp_bit(d, b)});
                @(posedge clk);
                #1;
            end
        end
        $display("frame byte=%h checked", d);
    endtask

    task automatic wait_idle(input int limit);
        logic [15:0] s;
        bit done = 0;
        for (int i = 0; i < limit && !done; i++) begin
            rd(16'h0206, s);
            if (s == 16'h0004) done = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("drain_timeout", {31'b0, done}, 32'd1);
    endtask

    logic [15:0] r;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_led", {8'h0, led}, 32'h0);
        check("reset_txd", {31'b0, txd}, 32'd1);
        rd(16'h0206, r);
        check("reset_status", {16'h0, r}, 32'h0004);

        // LED register and decode
        wr(16'h0200, 16'h1234);
        wr(16'h0202, 16'h00AB);
        check("led_value", {8'h0, led}, 32'h00AB1234);
        rd(16'h0202, r);
        check("read_led_hi", {16'h0, r}, 32'h00AB);
        rd(16'h0201, r);
        check("read_led_lo_odd", {16'h0, r}, 32'h1234);
        rd(16'h0204, r);
        check("read_txdata", {16'h0, r}, 32'h0);
        addr = 16'h0200; oe = 1'b0; #1;
        check("rdata_no_oe", {16'h0, rdata}, 32'h0);
        addr = 16'h01F0; #1;
        check("hit_1f0", {31'b0, hit}, 32'd0);
        addr = 16'h0208; #1;
        check("hit_208", {31'b0, hit}, 32'd0);
        addr = 16'h0207; #1;
        check("hit_207", {31'b0, hit}, 32'd1);

        // Single frame 0x55: txd still high after the push edge, low after the pop edge
        wr(16'h0204, 16'h0055);
        check("txd_after_push", {31'b0, txd}, 32'd1);
        @(posedge clk);
        #1;
        rd(16'h0206, r);
        check("status_busy", {16'h0, r}, 32'h0005);
        check_frame(8'h55);
        rd(16'h0206, r);
        check("status_after_frame", {16'h0, r}, 32'h0004);

        // Overflow: 5 back-to-back writes fit (first popped at once), then 4 more drop
        for (int i = 0; i < 5; i++) wr(16'h0204, 16'(8'h10 + i));
        rd(16'h0206, r);
        check("status_full_no_ovf", {16'h0, r}, 32'h0003);
        for (int i = 0; i < 4; i++) wr(16'h0204, 16'(8'h20 + i));
        rd(16'h0206, r);
        check("status_ovf", {16'h0, r}, 32'h000B);
        wr(16'h0206, 16'hFFFF);
        rd(16'h0206, r);
        check("status_ovf_cleared", {16'h0, r}, 32'h0003);
        wait_idle(600);

        // Back-to-back frames with no idle gap
        wr(16'h0204, 16'h0001);
        wr(16'h0204, 16'h0080);
        check_frame(8'h01);
        check_frame(8'h80);
        rd(16'h0206, r);
        check("status_after_b2b", {16'h0, r}, 32'h0004);

        // Reset mid-DATA
        wr(16'h0204, 16'h0055);
        @(posedge clk);
        #1;
        repeat (DIV + 2 * DIV) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_txd", {31'b0, txd}, 32'd1);
        check("rst_led", {8'h0, led}, 32'h0);
        rd(16'h0206, r);
        check("rst_status", {16'h0, r}, 32'h0004);
        wr(16'h0204, 16'h00A3);
        @(posedge clk);
        #1;
        check_frame(8'hA3);

`ifdef RISC16_IO_PARITY_EN
        wr(16'h0204, 16'h0007);
        @(posedge clk);
        #1;
        check_frame(8'h07);
        check("parity_idle_after", {31'b0, txd}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
